// File: rtl/lsc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsc_pkg
// Brief    : Shared types, tap table and LFSR step function for the LFSR
//            stream cipher engine.
// Revision : 1.0 - initial release
// ============================================================================
package lsc_pkg;

    localparam int LSC_DW = 8;

    // Index 0 lives in the least-significant byte.
    localparam logic [8*LSC_DW-1:0] TAPS_8 = {
        8'hf3, 8'hfa, 8'hb2, 8'hb4, 8'hb8, 8'hc6, 8'hd4, 8'he1
    };

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENC_PRE   = 3'd1,
        ST_ENC_MSG   = 3'd2,
        ST_ENC_POST  = 3'd3,
        ST_DEC_SEED  = 3'd4,
        ST_DEC_TRAIN = 3'd5,
        ST_DEC_RUN   = 3'd6,
        ST_FIN       = 3'd7
    } lsc_state_e;

    function automatic logic [LSC_DW-1:0] lfsr_step(input logic [LSC_DW-1:0] state,
                                                    input logic [LSC_DW-1:0] tap);
        return {state[LSC_DW-2:0], ^(state & tap)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsc_lfsr_bank.sv
`default_nettype none
// ============================================================================
// Module   : lsc_lfsr_bank
// Brief    : NPAT parallel LFSR candidates with survivor mask; lane 0 doubles
//            as the running key generator once a tap has been chosen.
// Revision : 1.0 - initial release
// ============================================================================
module lsc_lfsr_bank
    import lsc_pkg::*;
#(
    parameter int                   DW        = LSC_DW,
    parameter int                   NPAT      = 8,
    parameter logic [NPAT*DW-1:0]   TAP_TABLE = TAPS_8,
    localparam int                  SW        = $clog2(NPAT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [DW-1:0]   i_seed,
    input  logic            i_train,
    input  logic [DW-1:0]   i_ref,
    input  logic            i_finish,
    input  logic [SW-1:0]   i_sel,
    input  logic            i_run,
    input  logic [DW-1:0]   i_run_tap,
    output logic [DW-1:0]   o_lane0,
    output logic [DW-1:0]   o_run_next,
    output logic [NPAT-1:0] o_mask_next
);

    logic [DW-1:0]   r_state [NPAT];
    logic [NPAT-1:0] r_mask;
    logic [DW-1:0]   w_next  [NPAT];

    generate
        for (genvar k = 0; k < NPAT; k++) begin : g_lane
            assign w_next[k]      = lfsr_step(r_state[k], TAP_TABLE[k*DW +: DW]);
            assign o_mask_next[k] = r_mask[k] && (w_next[k] == i_ref);
        end
    endgenerate

    assign o_lane0    = r_state[0];
    assign o_run_next = lfsr_step(r_state[0], i_run_tap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPAT; k++) r_state[k] <= '0;
            r_mask <= '0;
        end else if (i_load) begin
            for (int k = 0; k < NPAT; k++) r_state[k] <= i_seed;
            r_mask <= '1;
        end else if (i_train) begin
            for (int k = 0; k < NPAT; k++) r_state[k] <= w_next[k];
            r_mask <= o_mask_next;
            // On the last training symbol the winner's state becomes the run key.
            if (i_finish) r_state[0] <= w_next[i_sel];
        end else if (i_run) begin
            r_state[0] <= o_run_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_stream_cipher.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_stream_cipher
// Brief    : Streaming LFSR encrypt/decrypt engine with padded fixed frames.
//            Option macro LSC_STRIP_LEADING_EN: drop leading PAD plaintexts.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_stream_cipher
    import lsc_pkg::*;
#(
    parameter int                   DW        = LSC_DW,
    parameter int                   NPAT      = 8,
    parameter logic [NPAT*DW-1:0]   TAP_TABLE = TAPS_8,
    parameter int                   FRAME_LEN = 64,
    parameter int                   MIN_PRE   = 9,
    parameter logic [DW-1:0]        PAD       = 8'h20,
    localparam int                  IW        = $clog2(FRAME_LEN),
    localparam int                  SW        = $clog2(NPAT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_cfg_valid,
    output logic            o_cfg_ready,
    input  logic            i_cfg_mode,
    input  logic [DW-1:0]   i_cfg_tap,
    input  logic [DW-1:0]   i_cfg_seed,
    input  logic [IW-1:0]   i_cfg_pre_len,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [DW-1:0]   i_in_data,
    input  logic            i_in_last,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [DW-1:0]   o_out_data,
    output logic            o_out_last,
    output logic            o_busy,
    output logic            o_done,
    output logic [1:0]      o_err,
    output logic [SW-1:0]   o_tap_idx
);

    localparam logic [IW-1:0] c_LAST      = IW'(FRAME_LEN - 1);
    localparam logic [IW-1:0] c_TRAIN_END = IW'(MIN_PRE - 1);
    localparam logic [IW-1:0] c_ONE       = IW'(1);
`ifdef LSC_STRIP_LEADING_EN
    localparam logic          c_STRIP     = 1'b1;
`else
    localparam logic          c_STRIP     = 1'b0;
`endif

    lsc_state_e      r_state;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_pre_len;
    logic [DW-1:0]   r_run_tap;
    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;
    logic            r_out_last;
    logic            r_done;
    logic [1:0]      r_err;
    logic [SW-1:0]   r_tap_idx;
    logic            r_stripping;

    logic            w_out_free;
    logic            w_in_ready;
    logic            w_in_hs;
    logic            w_cfg_hs;
    logic            w_load;
    logic [DW-1:0]   w_seed;
    logic            w_train;
    logic            w_finish;
    logic            w_run;
    logic [DW-1:0]   w_ref;
    logic [DW-1:0]   w_lane0;
    logic [DW-1:0]   w_run_next;
    logic [DW-1:0]   w_pt;
    logic [NPAT-1:0] w_mask_next;
    logic [SW-1:0]   w_sel;
    logic [DW-1:0]   w_sel_tap;
    logic            w_any;

    assign w_out_free = !r_out_valid || i_out_ready;
    assign w_cfg_hs   = (r_state == ST_IDLE) && i_cfg_valid;
    assign w_in_hs    = i_in_valid && w_in_ready;
    assign w_ref      = i_in_data ^ PAD;
    assign w_pt       = i_in_data ^ w_run_next;

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            ST_ENC_MSG:   w_in_ready = r_err[0] ? 1'b1 : w_out_free;
            ST_DEC_SEED,
            ST_DEC_TRAIN: w_in_ready = 1'b1;
            ST_DEC_RUN:   w_in_ready = r_err[1] ? 1'b1 : w_out_free;
            default:      w_in_ready = 1'b0;
        endcase
    end

    always_comb begin
        w_run = 1'b0;
        case (r_state)
            ST_ENC_PRE,
            ST_ENC_POST: w_run = w_out_free;
            ST_ENC_MSG:  w_run = w_in_hs && !r_err[0];
            ST_DEC_RUN:  w_run = w_in_hs && !r_err[1];
            default:     w_run = 1'b0;
        endcase
    end

    // Lowest surviving candidate wins.
    always_comb begin
        w_sel     = '0;
        w_sel_tap = TAP_TABLE[DW-1:0];
        for (int k = NPAT - 1; k >= 0; k--) begin
            if (w_mask_next[k]) begin
                w_sel     = SW'(k);
                w_sel_tap = TAP_TABLE[k*DW +: DW];
            end
        end
    end
    assign w_any = |w_mask_next;

    assign w_load   = (w_cfg_hs && !i_cfg_mode) || ((r_state == ST_DEC_SEED) && w_in_hs);
    assign w_seed   = (r_state == ST_DEC_SEED) ? w_ref : i_cfg_seed;
    assign w_train  = (r_state == ST_DEC_TRAIN) && w_in_hs;
    assign w_finish = (r_idx == c_TRAIN_END);

    lsc_lfsr_bank #(
        .DW        (DW),
        .NPAT      (NPAT),
        .TAP_TABLE (TAP_TABLE)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_seed      (w_seed),
        .i_train     (w_train),
        .i_ref       (w_ref),
        .i_finish    (w_finish),
        .i_sel       (w_sel),
        .i_run       (w_run),
        .i_run_tap   (r_run_tap),
        .o_lane0     (w_lane0),
        .o_run_next  (w_run_next),
        .o_mask_next (w_mask_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_pre_len   <= '0;
            r_run_tap   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= '0;
            r_tap_idx   <= '0;
            r_stripping <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_valid) begin
                        r_err       <= '0;
                        r_idx       <= '0;
                        r_run_tap   <= i_cfg_tap;
                        r_pre_len   <= i_cfg_pre_len;
                        r_stripping <= c_STRIP;
                        r_state     <= i_cfg_mode ? ST_DEC_SEED : ST_ENC_PRE;
                    end
                end
                ST_ENC_PRE: begin
                    if (w_out_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= PAD ^ w_lane0;
                        r_out_last  <= 1'b0;
                        r_idx       <= r_idx + c_ONE;
                        if (r_idx == r_pre_len - c_ONE) r_state <= ST_ENC_MSG;
                    end
                end
                ST_ENC_MSG: begin
                    if (w_in_hs) begin
                        if (r_err[0]) begin
                            if (i_in_last) r_state <= ST_FIN;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= i_in_data ^ w_lane0;
                            r_out_last  <= (r_idx == c_LAST);
                            r_idx       <= r_idx + c_ONE;
                            if (i_in_last)
                                r_state <= (r_idx == c_LAST) ? ST_FIN : ST_ENC_POST;
                            else if (r_idx == c_LAST)
                                r_err[0] <= 1'b1;
                        end
                    end
                end
                ST_ENC_POST: begin
                    if (w_out_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= PAD ^ w_lane0;
                        r_out_last  <= (r_idx == c_LAST);
                        r_idx       <= r_idx + c_ONE;
                        if (r_idx == c_LAST) r_state <= ST_FIN;
                    end
                end
                ST_DEC_SEED: begin
                    if (w_in_hs) begin
                        r_idx   <= c_ONE;
                        r_state <= ST_DEC_TRAIN;
                    end
                end
                ST_DEC_TRAIN: begin
                    if (w_in_hs) begin
                        r_idx <= r_idx + c_ONE;
                        if (r_idx == c_TRAIN_END) begin
                            if (w_any) begin
                                r_tap_idx <= w_sel;
                                r_run_tap <= w_sel_tap;
                            end else begin
                                r_err[1] <= 1'b1;
                            end
                            r_state <= ST_DEC_RUN;
                        end
                    end
                end
                ST_DEC_RUN: begin
                    if (w_in_hs) begin
                        r_idx <= r_idx + c_ONE;
                        if (!r_err[1]) begin
                            if (r_stripping && (w_pt == PAD)) begin
                                // A fully stripped frame still needs its closing beat.
                                if (r_idx == c_LAST) begin
                                    r_out_valid <= 1'b1;
                                    r_out_data  <= PAD;
                                    r_out_last  <= 1'b1;
                                end
                            end else begin
                                r_stripping <= 1'b0;
                                r_out_valid <= 1'b1;
                                r_out_data  <= w_pt;
                                r_out_last  <= (r_idx == c_LAST);
                            end
                        end
                        if (r_idx == c_LAST) r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (w_out_free) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cfg_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_tap_idx   = r_tap_idx;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stream_cipher.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_stream_cipher
// Brief    : Self-checking bench for lfsr_stream_cipher against a frame-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lfsr_stream_cipher;
    import lsc_pkg::*;

    localparam int          FL   = 64;
    localparam int          MP   = 9;
    localparam logic [7:0]  PADC = 8'h20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_cfg_valid, o_cfg_ready, i_cfg_mode;
    logic [7:0] i_cfg_tap, i_cfg_seed;
    logic [5:0] i_cfg_pre_len;
    logic       i_in_valid, o_in_ready, i_in_last;
    logic [7:0] i_in_data;
    logic       o_out_valid, i_out_ready, o_out_last;
    logic [7:0] o_out_data;
    logic       o_busy, o_done;
    logic [1:0] o_err;
    logic [2:0] o_tap_idx;

    always #5 clk = ~clk;

    lfsr_stream_cipher dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_mode(i_cfg_mode),
        .i_cfg_tap(i_cfg_tap), .i_cfg_seed(i_cfg_seed), .i_cfg_pre_len(i_cfg_pre_len),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .i_in_last(i_in_last), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_data(o_out_data), .o_out_last(o_out_last), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err), .o_tap_idx(o_tap_idx)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] tx_q [$];
    logic [7:0] rx_d [$];
    bit         rx_l [$];
    logic [7:0] exp_q [$];
    logic [7:0] ref_q [$];
    logic [7:0] ct_save [$];
    logic [1:0] exp_err;
    int         exp_tap;
    bit         stall_en = 1'b0;
    bit         abort    = 1'b0;
    bit         snd_done;
    int         done_cnt = 0;
    int         n_sent;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            i_out_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && o_out_valid && i_out_ready) begin
            rx_d.push_back(o_out_data);
            rx_l.push_back(o_out_last);
        end
        if (o_done) done_cnt++;
    end

    function automatic logic [7:0] bstep(input logic [7:0] s, input logic [7:0] t);
        return {s[6:0], ^(s & t)};
    endfunction

    // Whole-frame view: plaintext frame = preamble, message, trailing pad.
    task automatic model_enc(input logic [7:0] tap, input logic [7:0] seed, input int pre);
        logic [7:0] s, p;
        exp_q.delete();
        s = seed;
        for (int i = 0; i < FL; i++) begin
            if (i < pre)                  p = PADC;
            else if (i - pre < tx_q.size()) p = tx_q[i - pre];
            else                          p = PADC;
            exp_q.push_back(p ^ s);
            s = bstep(s, tap);
        end
        exp_err = {1'b0, tx_q.size() > FL - pre};
    endtask

    task automatic model_dec();
        logic [7:0] seed, s, pt, tap;
        bit ok, strip;
        exp_q.delete();
        seed    = tx_q[0] ^ PADC;
        exp_tap = -1;
        for (int k = 0; k < 8; k++) begin
            if (exp_tap < 0) begin
                s  = seed;
                ok = 1'b1;
                for (int i = 1; i < MP; i++) begin
                    s = bstep(s, TAPS_8[k*8 +: 8]);
                    if (s != (tx_q[i] ^ PADC)) ok = 1'b0;
                end
                if (ok) exp_tap = k;
            end
        end
        if (exp_tap < 0) begin
            exp_err = 2'b10;
        end else begin
            exp_err = 2'b00;
            tap = TAPS_8[exp_tap*8 +: 8];
`ifdef LSC_STRIP_LEADING_EN
            strip = 1'b1;
`else
            strip = 1'b0;
`endif
            s = seed;
            for (int i = 1; i < FL; i++) begin
                s = bstep(s, tap);
                if (i >= MP) begin
                    pt = tx_q[i] ^ s;
                    if (strip && pt == PADC) begin
                        if (i == FL - 1) exp_q.push_back(PADC);
                    end else begin
                        strip = 1'b0;
                        exp_q.push_back(pt);
                    end
                end
            end
        end
    endtask

    task automatic do_cfg(input bit mode, input logic [7:0] tap, input logic [7:0] seed,
                          input logic [5:0] pre);
        @(posedge clk); #1;
        i_cfg_mode = mode; i_cfg_tap = tap; i_cfg_seed = seed; i_cfg_pre_len = pre;
        i_cfg_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (o_cfg_ready) break;
        end
        @(posedge clk); #1;
        i_cfg_valid = 1'b0;
    endtask

    task automatic send_tx();
        bit hs;
        n_sent = 0;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (abort) break;
            i_in_valid = 1'b1;
            i_in_data  = tx_q[i];
            i_in_last  = (i == tx_q.size() - 1);
            hs = 1'b0;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                if (abort) break;
                if (o_in_ready) begin hs = 1'b1; break; end
            end
            if (!hs) break;
            @(posedge clk); #1;
            n_sent++;
        end
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
    endtask

    task automatic run(input bit mode, input logic [7:0] tap, input logic [7:0] seed,
                       input logic [5:0] pre, input string tag);
        bit seen;
        rx_d.delete(); rx_l.delete();
        done_cnt = 0;
        do_cfg(mode, tap, seed, pre);
        send_tx();
        seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (o_done) begin seen = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        check({tag, "_done_seen"}, seen, 1);
    endtask

    task automatic cmp_rx(input string tag);
        int mism = 0;
        check({tag, "_count"}, rx_d.size(), exp_q.size());
        for (int i = 0; i < rx_d.size() && i < exp_q.size(); i++) begin
            if (rx_d[i] !== exp_q[i]) mism++;
            if (rx_l[i] !== (i == exp_q.size() - 1)) mism++;
        end
        check({tag, "_mismatches"}, mism, 0);
        check({tag, "_err"}, o_err, exp_err);
        check({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        logic [7:0] tap, seed;
        int pre, len, mism;

        rst_n = 1'b0;
        i_cfg_valid = 1'b0; i_cfg_mode = 1'b0; i_cfg_tap = '0; i_cfg_seed = '0;
        i_cfg_pre_len = '0; i_in_valid = 1'b0; i_in_data = '0; i_in_last = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_cfg_ready", o_cfg_ready, 1);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err, 0);
        check("rst_tap_idx", o_tap_idx, 0);
        check("rst_in_ready", o_in_ready, 0);
        rst_n = 1'b1;

        // "Mr." with tap d4, seed 41, preamble 9
        tx_q = '{8'h4D, 8'h72, 8'h2E};
        model_enc(8'hd4, 8'h41, 9);
        run(1'b0, 8'hd4, 8'h41, 6'd9, "enc1");
        check("enc1_sym0", (rx_d.size() > 0) ? rx_d[0] : 32'hFFFF, 8'h61);
        check("enc1_sym1", (rx_d.size() > 1) ? rx_d[1] : 32'hFFFF, 8'hA3);
        check("enc1_len", rx_d.size(), FL);
        cmp_rx("enc1");

        // "Ajok" with tap fa, seed 48, preamble 10, then decrypt it
        tx_q = '{8'h41, 8'h6A, 8'h6F, 8'h6B};
        model_enc(8'hfa, 8'h48, 10);
        run(1'b0, 8'hfa, 8'h48, 6'd10, "enc2");
        cmp_rx("enc2");
        ct_save = exp_q;
        tx_q    = exp_q;
        model_dec();
        run(1'b1, 8'h00, 8'h00, 6'd0, "dec2");
        check("dec2_tap_idx", o_tap_idx, 6);
`ifndef LSC_STRIP_LEADING_EN
        check("dec2_len", rx_d.size(), FL - MP);
`endif
        cmp_rx("dec2");

        // 41-byte message, first without and then with output backpressure
        tap  = TAPS_8[$urandom_range(0, 7)*8 +: 8];
        seed = 8'($urandom_range(1, 255));
        pre  = $urandom_range(9, 23);
        tx_q.delete();
        for (int i = 0; i < 41; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        model_enc(tap, seed, pre);
        run(1'b0, tap, seed, 6'(pre), "bp0");
        cmp_rx("bp0");
        ref_q = rx_d;
        stall_en = 1'b1;
        run(1'b0, tap, seed, 6'(pre), "bp1");
        stall_en = 1'b0;
        cmp_rx("bp1");
        mism = 0;
        for (int i = 0; i < ref_q.size() && i < rx_d.size(); i++)
            if (ref_q[i] !== rx_d[i]) mism++;
        check("bp_vs_nostall", mism + ((ref_q.size() == rx_d.size()) ? 0 : 1000), 0);

        // Overflow: preamble 11 plus 60 bytes
        tx_q.delete();
        for (int i = 0; i < 60; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        model_enc(8'hb8, 8'h5A, 11);
        run(1'b0, 8'hb8, 8'h5A, 6'd11, "ovf");
        check("ovf_err0", o_err[0], 1);
        check("ovf_drained", n_sent, 60);
        cmp_rx("ovf");

        // Corrupted ciphertext byte 3: no tap may survive training
        tx_q = ct_save;
        tx_q[3] = tx_q[3] ^ 8'h01;
        model_dec();
        run(1'b1, 8'h00, 8'h00, 6'd0, "decbad");
        check("decbad_inputs", n_sent, FL);
        cmp_rx("decbad");

        // Random encrypt/decrypt round trips, with backpressure
        stall_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tap  = TAPS_8[$urandom_range(0, 7)*8 +: 8];
            seed = 8'($urandom_range(1, 255));
            pre  = $urandom_range(9, 20);
            len  = $urandom_range(1, FL - pre);
            tx_q.delete();
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            model_enc(tap, seed, pre);
            run(1'b0, tap, seed, 6'(pre), "rt_enc");
            cmp_rx("rt_enc");
            tx_q = exp_q;
            model_dec();
            run(1'b1, 8'h00, 8'h00, 6'd0, "rt_dec");
            check("rt_dec_tap_idx", o_tap_idx, exp_tap);
            cmp_rx("rt_dec");
        end
        stall_en = 1'b0;

        // Reset in the middle of an encrypt frame
        tx_q.delete();
        for (int i = 0; i < 40; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        rx_d.delete(); rx_l.delete();
        done_cnt = 0;
        snd_done = 1'b0;
        do_cfg(1'b0, 8'hc6, 8'h33, 6'd9);
        fork
            begin send_tx(); snd_done = 1'b1; end
        join_none
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (rx_d.size() >= 20) break;
        end
        check("mid_reached_20", rx_d.size() >= 20, 1);
        abort = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", o_out_valid, 0);
        check("mid_rst_out_last", o_out_last, 0);
        check("mid_rst_out_data", o_out_data, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_err", o_err, 0);
        check("mid_rst_cfg_ready", o_cfg_ready, 1);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (snd_done) break;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        check("post_rst_cfg_ready", o_cfg_ready, 1);
        check("post_rst_no_done", done_cnt, 0);

        tx_q = '{8'h4D, 8'h72, 8'h2E};
        model_enc(8'hd4, 8'h41, 9);
        run(1'b0, 8'hd4, 8'h41, 6'd9, "after_rst");
        cmp_rx("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
